// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - circular return-address stack for call/return prediction
module return_addr_stack #(
  parameter int N     = 32,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [N-1:0]     push_data,
  output logic [N-1:0]     top_data,
  output logic             valid,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  // Occupancy is decoded from count; there is no separate state register.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_t;

  logic [N-1:0]     entry [DEPTH];
  logic [PTR_W-1:0] tos;
  logic [PTR_W-1:0] tos_inc;
  logic [PTR_W-1:0] tos_dec;

  occ_t             occ;
  logic             push_eff;
  logic [PTR_W-1:0] next_tos;
  logic [PTR_W:0]   next_count;
  logic             next_overflow;
  logic             next_underflow;
  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;

  // Pointer neighbours; PTR_W-bit arithmetic wraps modulo DEPTH.
  assign tos_inc = tos + 1'b1;
  assign tos_dec = tos - 1'b1;

  // A zero link address is treated as no push at all.
  assign push_eff = push && (push_data != '0);

  // Derive the occupancy class from the entry count.
  always_comb begin
    occ = OCC_PARTIAL;
    if (count == '0) begin
      occ = OCC_EMPTY;
    end else if (count == FULL_COUNT) begin
      occ = OCC_FULL;
    end
  end

  // Next-state and storage-write decode for push/pop/flush combinations.
  always_comb begin
    next_tos       = tos;
    next_count     = count;
    next_overflow  = 1'b0;
    next_underflow = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = tos_inc;

    if (flush) begin
      next_tos   = '0;
      next_count = '0;
    end else if (push_eff && pop && (occ != OCC_EMPTY)) begin
      // Call and return together: replace the top entry in place.
      wr_en   = 1'b1;
      wr_addr = tos;
    end else if (push_eff) begin
      // Plain push, or push+pop on an empty stack.
      wr_en    = 1'b1;
      wr_addr  = tos_inc;
      next_tos = tos_inc;
      if (occ == OCC_FULL) begin
        next_overflow = 1'b1;
      end else begin
        next_count = count + 1'b1;
      end
    end else if (pop) begin
      if (occ == OCC_EMPTY) begin
        next_underflow = 1'b1;
      end else begin
        next_tos   = tos_dec;
        next_count = count - 1'b1;
      end
    end
  end

  // Pointer, count and pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tos       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      tos       <= next_tos;
      count     <= next_count;
      overflow  <= next_overflow;
      underflow <= next_underflow;
    end
  end

  // Entry storage; cleared on reset, untouched by flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= '0;
      end
    end else if (wr_en) begin
      entry[wr_addr] <= push_data;
    end
  end

  // Outputs are combinational from registered state.
  always_comb begin
    top_data = '0;
    valid    = (count != '0);
    if (count != '0) begin
      top_data = entry[tos];
    end
  end

endmodule
